// File: rtl/jtopl_mmr3.sv
// OPL/OPL2/OPL3 register write decoder with post-write busy pacing.
// Turns CPU address/data writes into timer, global, 4-op and slot/channel update controls.
module jtopl_mmr3 #(
   parameter int OPL_TYPE  = 1,
   parameter int ADDR_WAIT = 12,
   parameter int DATA_WAIT = 84
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen_op,
   input  logic [7:0] din,
   input  logic       write,
   input  logic [1:0] addr,
   output logic       busy,
   output logic       wr_drop,
   output logic [7:0] din_copy,
   output logic       sel_bank,
   output logic [1:0] sel_group,
   output logic [2:0] sel_sub,
   output logic       up_mult,
   output logic       up_ksl_tl,
   output logic       up_ar_dr,
   output logic       up_sl_rr,
   output logic       up_wav,
   output logic       up_fnumlo,
   output logic       up_fnumhi,
   output logic       up_fbcon,
   output logic [7:0] value_A,
   output logic [7:0] value_B,
   output logic       load_A,
   output logic       load_B,
   output logic       flagen_A,
   output logic       flagen_B,
   output logic       clr_flag_A,
   output logic       clr_flag_B,
   output logic       am_dep,
   output logic       vib_dep,
   output logic       rhy_en,
   output logic [4:0] rhy_kon,
   output logic       wave_mode,
   output logic       new_mode,
   output logic [5:0] conn4op
);

   localparam int CW = (DATA_WAIT > 0) ? $clog2(DATA_WAIT + 1) : 1;

   logic [CW-1:0] r_wait;
   logic [7:0]    r_selreg;
   logic          r_selbank;

   logic          w_acc;
   logic          w_awr;
   logic          w_dwr;
   logic          w_b0;
   logic          w_dec_en;
   logic          w_op_rng;
   logic          w_ch_rng;
   logic [3:0]    w_ch;
   logic [1:0]    w_ch_grp;
   logic [2:0]    w_ch_sub;

   assign busy  = |r_wait;
   assign w_acc = write & ~busy;
   assign w_awr = w_acc & ~addr[0];
   assign w_dwr = w_acc &  addr[0];

   always_comb begin
      w_b0     = ~r_selbank;
      // bank-1 registers are locked behind NEW mode, except the NEW bit itself
      w_dec_en = w_b0 | new_mode | (r_selreg == 8'h05);
      w_op_rng = ((r_selreg >= 8'h20 && r_selreg <= 8'h9F) ||
                  (r_selreg >= 8'hE0 && r_selreg <= 8'hF5)) &&
                 (r_selreg[2:0] <= 3'd5) && (r_selreg[4:3] != 2'd3);
      w_ch_rng = (r_selreg[7:4] >= 4'hA) && (r_selreg[7:4] <= 4'hC) &&
                 (r_selreg[3:0] <= 4'd8);
      w_ch     = r_selreg[3:0];
      w_ch_grp = (w_ch >= 4'd6) ? 2'd2 : (w_ch >= 4'd3) ? 2'd1 : 2'd0;
      w_ch_sub = (w_ch < 4'd6) ? w_ch[2:0] : {1'b0, ~&w_ch[2:1], w_ch[0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait     <= '0;
         r_selreg   <= '0;
         r_selbank  <= 1'b0;
         wr_drop    <= 1'b0;
         din_copy   <= '0;
         sel_bank   <= 1'b0;
         sel_group  <= '0;
         sel_sub    <= '0;
         up_mult    <= 1'b0;
         up_ksl_tl  <= 1'b0;
         up_ar_dr   <= 1'b0;
         up_sl_rr   <= 1'b0;
         up_wav     <= 1'b0;
         up_fnumlo  <= 1'b0;
         up_fnumhi  <= 1'b0;
         up_fbcon   <= 1'b0;
         value_A    <= '0;
         value_B    <= '0;
         load_A     <= 1'b0;
         load_B     <= 1'b0;
         flagen_A   <= 1'b1;
         flagen_B   <= 1'b1;
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         am_dep     <= 1'b0;
         vib_dep    <= 1'b0;
         rhy_en     <= 1'b0;
         rhy_kon    <= '0;
         wave_mode  <= 1'b0;
         new_mode   <= 1'b0;
         conn4op    <= '0;
      end else begin
         wr_drop <= write & busy;

         if (w_awr)
            r_wait <= CW'(ADDR_WAIT);
         else if (w_dwr)
            r_wait <= CW'(DATA_WAIT);
         else if (busy)
            r_wait <= r_wait - CW'(1);

         if (!w_acc && cen_op) begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
         end

         if (w_awr) begin
            r_selreg  <= din;
            r_selbank <= (OPL_TYPE == 3) ? addr[1] : 1'b0;
         end

         if (w_dwr) begin
            din_copy  <= din;
            up_mult   <= 1'b0;
            up_ksl_tl <= 1'b0;
            up_ar_dr  <= 1'b0;
            up_sl_rr  <= 1'b0;
            up_wav    <= 1'b0;
            up_fnumlo <= 1'b0;
            up_fnumhi <= 1'b0;
            up_fbcon  <= 1'b0;
            if (w_dec_en) begin
               if (w_b0) begin
                  case (r_selreg)
                     8'h01: if (OPL_TYPE >= 2) wave_mode <= din[5];
                     8'h02: value_A <= din;
                     8'h03: value_B <= din;
                     8'h04: begin
                        clr_flag_A <= din[7];
                        clr_flag_B <= din[7];
                        flagen_A   <= ~din[6];
                        flagen_B   <= ~din[5];
                        load_B     <= din[1];
                        load_A     <= din[0];
                     end
                     8'hBD: {am_dep, vib_dep, rhy_en, rhy_kon} <= din;
                     default: ;
                  endcase
               end else begin
                  if (r_selreg == 8'h05) new_mode <= din[0];
                  if (r_selreg == 8'h04) conn4op  <= din[5:0];
               end
               if (w_op_rng) begin
                  sel_bank  <= r_selbank;
                  sel_group <= r_selreg[4:3];
                  sel_sub   <= r_selreg[2:0];
                  case (r_selreg[7:5])
                     3'd1: up_mult   <= 1'b1;
                     3'd2: up_ksl_tl <= 1'b1;
                     3'd3: up_ar_dr  <= 1'b1;
                     3'd4: up_sl_rr  <= 1'b1;
                     3'd7: up_wav    <= wave_mode | new_mode;
                     default: ;
                  endcase
               end
               if (w_ch_rng) begin
                  sel_bank  <= r_selbank;
                  sel_group <= w_ch_grp;
                  sel_sub   <= w_ch_sub;
                  case (r_selreg[7:4])
                     4'hA: up_fnumlo <= 1'b1;
                     4'hB: up_fnumhi <= 1'b1;
                     4'hC: up_fbcon  <= 1'b1;
                     default: ;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: doc/jtopl_mmr3.md
# jtopl_mmr3

Register write decoder and write-pacing controller for the OPL family, generalised from OPL/OPL2 to OPL3. It accepts CPU address/data writes across two register banks and decodes them into timer controls, global LFO/rhythm settings, 4-operator connection bits, and per-slot/per-channel update strobes with group/sub/bank selection for the register file. It also enforces the chip's post-write wait times with a busy flag, and drops writes that arrive while busy. It sits between the CPU bus interface and the slot register file / timers.

## Interface
- OPL_TYPE, 1: 1=OPL, 2=OPL2 (waveform select), 3=OPL3 (second bank, 4-op, NEW mode)
- ADDR_WAIT, 12: clk cycles the block stays busy after an accepted address write; 0 disables
- DATA_WAIT, 84: clk cycles the block stays busy after an accepted data write; 0 disables; must be ≥ ADDR_WAIT
- clk  in  1  single clock; every register in the block uses it
- rst_n  in  1  asynchronous, active-low reset
- cen_op  in  1  operator clock enable from the divider
- din  in  8  CPU write data
- write  in  1  write strobe, one clk per access
- addr  in  2  [0]: 0=address, 1=data; [1]: bank (ignored unless OPL_TYPE==3)
- busy  out  1  wait counter nonzero
- wr_drop  out  1  one-clk pulse: write rejected because busy
- din_copy  out  8  last accepted data byte
- sel_bank / sel_group / sel_sub  out  1/2/3  target of the last operator or channel write
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon  out  1 each  update flags
- value_A, value_B  out  8 each; load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B  out  1 each
- am_dep, vib_dep, rhy_en  out  1 each; rhy_kon  out  5
- wave_mode, new_mode  out  1 each; conn4op  out  6

## Operation
- Accepted write: write=1 and busy=0. A write with busy=1 changes no state except that it asserts wr_drop for 1 clk.
- Address write (addr[0]=0):
  - selreg is set to din.
  - selbank is set to addr[1] when OPL_TYPE==3; otherwise it is 0.
  - The wait counter loads ADDR_WAIT.
- Data write (addr[0]=1):
  - din_copy is set to din and all eight up_* flags clear.
  - Decode then proceeds on {selbank, selreg}.
  - The wait counter loads DATA_WAIT.
- Bank-0 globals:
  - 0x01: wave_mode is set to din[5] if OPL_TYPE≥2; otherwise it stays 0.
  - 0x02: value_A is set to din.
  - 0x03: value_B is set to din.
  - 0x04: clr_flag_A and clr_flag_B are set to din[7]. flagen_A is set to ~din[6] and flagen_B to ~din[5]. {load_B, load_A} is set to din[1:0].
  - 0xBD: {am_dep, vib_dep, rhy_en, rhy_kon} is set to din[7:0].
- Bank-1, OPL_TYPE==3 only:
  - 0x105: new_mode is set to din[0]. This write is always decoded.
  - 0x104: conn4op is set to din[5:0]. Only decoded when new_mode=1.
  - Any other bank-1 register is decoded only when new_mode=1. Bank-1 timer/global addresses (0x02–0x04, 0xBD) are ignored.
- Operator registers:
  - Range: selreg in 0x20–0x9F or 0xE0–0xF5, with selreg[2:0]≤5 and selreg[4:3]≠3.
  - sel_group is set to selreg[4:3], sel_sub to selreg[2:0], and sel_bank to selbank.
  - Flags by selreg[7:5]: 1 sets up_mult, 2 up_ksl_tl, 3 up_ar_dr, 4 up_sl_rr, 7 up_wav.
  - up_wav is set only if wave_mode | new_mode.
- Channel registers:
  - Range: selreg[7:4] in {A, B, C} and selreg[3:0]≤8.
  - A sets up_fnumlo, B sets up_fnumhi, C sets up_fbcon.
  - sel_group is set to ch/3, where ch = selreg[3:0].
  - sel_sub is set to ch when ch<6; otherwise to {0, ~&ch[2:1], ch[0]}.
  - sel_bank is set to selbank.
- up_* flags hold until the next accepted data write.
- When no write is accepted in a clk with cen_op=1, clr_flag_A and clr_flag_B clear.

## Timing
- Reset (rst_n=0, async):
  - flagen_A = flagen_B = 1.
  - Every other output is 0; selreg, selbank and the wait counter are also 0.
- All outputs update on the clk edge after the accepted write; latency is 1 clk.
- busy rises on the edge after an accepted write and stays high for exactly the loaded wait value in clks.
  - The counter decrements each clk and saturates at 0. Counter width is clog2(DATA_WAIT+1).
  - The write on the clk where the counter reaches 0 is accepted.
- Accepted write and cen_op in the same clk: the write wins, and clr flags take the value written.
- A reset asserted mid-busy zeroes the counter immediately; busy falls asynchronously.
- If the wait parameter for a write type is 0, that write type never asserts busy, and back-to-back writes in consecutive clks are all accepted.

## Test plan
- Pacing:
  - Stimulus: addr 0x02, then data 0xA5 at clk+13 (ADDR_WAIT=12).
  - Required: value_A=0xA5; busy high for 12 clks, then 84.
- Drop while busy:
  - Stimulus: data write 0x04 ← 0x80 at clk+5 after an address write.
  - Required: wr_drop pulses 1 clk; clr_flag_A stays 0; selreg is unchanged.
- Timer control:
  - Stimulus: 0x04 ← 0xE3, then idle.
  - Required: clr_flag_A/B=1 until the first cen_op clk; flagen_A=flagen_B=0; load_A=load_B=1.
- Channel decode:
  - Stimulus: OPL_TYPE=3, new_mode=1, bank-1 0xA7 ← 0x44.
  - Required: up_fnumlo=1; sel_bank=1, sel_group=2, sel_sub=1.
- Mode gating:
  - Stimulus: OPL_TYPE=3, new_mode=0, bank-1 0x104 ← 0x3F, then 0x105 ← 0x01, then 0x104 ← 0x3F.
  - Required: conn4op stays 0 after the first write, then becomes 0x3F.
- Waveform gating:
  - Stimulus: OPL_TYPE=2, wave_mode=0, 0xE0 ← 0x02.
  - Required: up_wav=0.
  - Stimulus: 0x01 ← 0x20, then 0xE0 ← 0x02.
  - Required: up_wav=1, sel_group=0, sel_sub=0.
